// File: rtl/video_src_switch.sv
// Frame-aligned source switch between the internal test pattern and live video ahead of the HDMI transmitter.
// Define SRC_WATCHDOG_EN to build the live-source watchdog with automatic fallback to the test pattern.
module video_src_switch #(
    parameter logic video_hsync_pol = 1'b1,
    parameter logic video_vsync_pol = 1'b1,
    parameter int   wd_timeout      = 4950000
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        sel_live,
    input  logic        tp_vsync,
    input  logic        tp_hsync,
    input  logic        tp_den,
    input  logic        tp_line_start,
    input  logic [23:0] tp_pixel_even,
    input  logic [23:0] tp_pixel_odd,
    input  logic        live_vsync,
    input  logic        live_hsync,
    input  logic        live_den,
    input  logic        live_line_start,
    input  logic [23:0] live_pixel_even,
    input  logic [23:0] live_pixel_odd,
    output logic        video_vsync,
    output logic        video_hsync,
    output logic        video_den,
    output logic        video_line_start,
    output logic [23:0] video_pixel_even,
    output logic [23:0] video_pixel_odd,
    output logic        src_live,
    output logic        switch_busy,
    output logic        live_lost
);

    typedef struct packed {
        logic        vsync;
        logic        hsync;
        logic        den;
        logic        lineStart;
        logic [23:0] pixelEven;
        logic [23:0] pixelOdd;
    } video_t;

    typedef enum logic [1:0] {
        ST_TP,
        ST_LIVE,
        ST_WAIT_CUR,
        ST_BLANK
    } state_t;

    localparam video_t BLANK_VIDEO = '{
        vsync:     ~video_vsync_pol,
        hsync:     ~video_hsync_pol,
        den:       1'b0,
        lineStart: 1'b0,
        pixelEven: 24'd0,
        pixelOdd:  24'd0
    };

    state_t r_state;
    logic   r_target;
    logic   r_srcLive;
    logic   r_busy;
    video_t r_video;
    logic   r_tpVsPrev;
    logic   r_liveVsPrev;

    video_t w_tp;
    video_t w_live;
    video_t w_curBus;
    video_t w_tgtBus;
    logic   w_tpVse;
    logic   w_liveVse;
    logic   w_curVse;
    logic   w_tgtVse;
    logic   w_lost;

    assign w_tp   = {tp_vsync, tp_hsync, tp_den, tp_line_start, tp_pixel_even, tp_pixel_odd};
    assign w_live = {live_vsync, live_hsync, live_den, live_line_start, live_pixel_even, live_pixel_odd};

    assign w_tpVse   = (tp_vsync == video_vsync_pol) && (r_tpVsPrev != video_vsync_pol);
    assign w_liveVse = (live_vsync == video_vsync_pol) && (r_liveVsPrev != video_vsync_pol);

    // The source currently on screen is tracked by r_srcLive; the destination by r_target.
    assign w_curVse = r_srcLive ? w_liveVse : w_tpVse;
    assign w_tgtVse = r_target ? w_liveVse : w_tpVse;
    assign w_curBus = r_srcLive ? w_live : w_tp;
    assign w_tgtBus = r_target ? w_live : w_tp;

`ifdef SRC_WATCHDOG_EN
    localparam logic [23:0] WD_LIMIT = 24'(wd_timeout);

    logic [23:0] r_wdCount;

    // Starts saturated so the live source is presumed absent until its first frame start.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_wdCount <= WD_LIMIT;
        end else if (w_liveVse) begin
            r_wdCount <= 24'd0;
        end else if (r_wdCount != WD_LIMIT) begin
            r_wdCount <= r_wdCount + 24'd1;
        end
    end

    assign w_lost = (r_wdCount == WD_LIMIT);
`else
    assign w_lost = 1'b0;
`endif

    // The output register always captures the selection of the state being entered on this edge.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_TP;
            r_target     <= 1'b0;
            r_srcLive    <= 1'b0;
            r_busy       <= 1'b0;
            r_video      <= BLANK_VIDEO;
            r_tpVsPrev   <= ~video_vsync_pol;
            r_liveVsPrev <= ~video_vsync_pol;
        end else begin
            r_tpVsPrev   <= tp_vsync;
            r_liveVsPrev <= live_vsync;
            case (r_state)
                ST_TP: begin
                    r_video <= w_tp;
                    if (sel_live && !w_lost) begin
                        r_state  <= ST_WAIT_CUR;
                        r_target <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_LIVE: begin
                    if (w_lost) begin
                        r_state  <= ST_BLANK;
                        r_target <= 1'b0;
                        r_busy   <= 1'b1;
                        r_video  <= BLANK_VIDEO;
                    end else begin
                        r_video <= w_live;
                        if (!sel_live) begin
                            r_state  <= ST_WAIT_CUR;
                            r_target <= 1'b0;
                            r_busy   <= 1'b1;
                        end
                    end
                end
                ST_WAIT_CUR: begin
                    // A lost live source will never deliver the frame end we are waiting for.
                    if (r_srcLive && w_lost) begin
                        r_state  <= ST_BLANK;
                        r_target <= 1'b0;
                        r_video  <= BLANK_VIDEO;
                    end else if (sel_live == r_srcLive) begin
                        r_state <= r_srcLive ? ST_LIVE : ST_TP;
                        r_busy  <= 1'b0;
                        r_video <= w_curBus;
                    end else if (w_curVse) begin
                        r_state <= ST_BLANK;
                        r_video <= BLANK_VIDEO;
                    end else begin
                        r_video <= w_curBus;
                    end
                end
                ST_BLANK: begin
                    if (r_target && w_lost) begin
                        r_target <= 1'b0;
                        r_video  <= BLANK_VIDEO;
                    end else if (w_tgtVse) begin
                        r_state   <= r_target ? ST_LIVE : ST_TP;
                        r_srcLive <= r_target;
                        r_busy    <= 1'b0;
                        r_video   <= w_tgtBus;
                    end else begin
                        r_video <= BLANK_VIDEO;
                    end
                end
                default: begin
                    r_state <= ST_TP;
                    r_video <= BLANK_VIDEO;
                end
            endcase
        end
    end

    assign video_vsync      = r_video.vsync;
    assign video_hsync      = r_video.hsync;
    assign video_den        = r_video.den;
    assign video_line_start = r_video.lineStart;
    assign video_pixel_even = r_video.pixelEven;
    assign video_pixel_odd  = r_video.pixelOdd;
    assign src_live         = r_srcLive;
    assign switch_busy      = r_busy;
    assign live_lost        = w_lost;

endmodule
